// File: rtl/divider_seq_param_if.sv
// -----------------------------------------------------------------------------
// divider_seq_param_if
// Handshake and data bundle for the iterative divider.
//   in_valid / in_ready          : operation request / block idle and accepting
//   signed_mode                  : 1 = signed division, sampled with the operands
//   dividend / divisor           : WIDTH-bit operands
//   out_valid / out_ready        : result available / consumer accepts result
//   quotient / remainder         : registered results
//   div_by_zero / overflow       : special-case flags, qualified by out_valid
//   busy                         : iteration or sign-fix in progress
// master = requester side, slave = divider side.
// -----------------------------------------------------------------------------
interface divider_seq_param_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             signed_mode;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic             overflow;
   logic             busy;

   modport master (
      output in_valid, signed_mode, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
   );

   modport slave (
      input  in_valid, signed_mode, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
   );
endinterface

// File: rtl/divider_seq_param.sv
// -----------------------------------------------------------------------------
// divider_seq_param
// Iterative restoring radix-2 integer divider, one quotient bit per clock.
// Signed (truncating, remainder takes the dividend's sign) or unsigned,
// selected per operation. Zero divisor and signed most-negative / -1 are
// resolved on the accept edge with fixed results and a flag.
// Ports:
//   clk      : rising-edge clock
//   sync_rst : synchronous active-high reset, priority over everything
//   bus      : divider_seq_param_if.slave (handshakes, operands, results, flags)
// Latency accept -> out_valid: WIDTH+1 edges (normal), 1 edge (special cases).
// -----------------------------------------------------------------------------
module divider_seq_param #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               sync_rst,
   divider_seq_param_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       r_state;
   logic             r_a_neg;      // dividend sign (0 in unsigned mode)
   logic             r_b_neg;      // divisor sign (0 in unsigned mode)
   logic [WIDTH-1:0] r_work;       // dividend magnitude, shifts into quotient
   logic [WIDTH-1:0] r_dsr;        // divisor magnitude
   // Partial remainder. A kept trial is always non-negative and below the
   // divisor, so its top (WIDTH+1-th) bit is always 0 and is not stored.
   logic [WIDTH-1:0] r_prem;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_dbz;
   logic             r_ovf;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic             w_zero;
   logic             w_ovf;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic             w_qbit;
   logic             w_last;

   assign w_a_neg = bus.signed_mode & bus.dividend[WIDTH-1];
   assign w_b_neg = bus.signed_mode & bus.divisor[WIDTH-1];
   // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
   assign w_a_mag = w_a_neg ? -bus.dividend : bus.dividend;
   assign w_b_mag = w_b_neg ? -bus.divisor : bus.divisor;
   assign w_zero  = (bus.divisor == '0);
   assign w_ovf   = bus.signed_mode && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                    && (bus.divisor == '1);

   // Shift {remainder, dividend} left one place, then trial-subtract the divisor.
   assign w_shift = {r_prem, r_work[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, r_dsr};
   assign w_qbit  = ~w_trial[WIDTH];
   assign w_last  = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         r_state     <= S_IDLE;
         r_a_neg     <= 1'b0;
         r_b_neg     <= 1'b0;
         r_work      <= '0;
         r_dsr       <= '0;
         r_prem      <= '0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_a_neg <= w_a_neg;
                  r_b_neg <= w_b_neg;
                  r_work  <= w_a_mag;
                  r_dsr   <= w_b_mag;
                  r_prem  <= '0;
                  r_cnt   <= '0;
                  if (w_zero) begin
                     r_quotient  <= '1;
                     r_remainder <= bus.dividend;
                     r_dbz       <= 1'b1;
                     r_ovf       <= 1'b0;
                     r_state     <= S_DONE;
                  end else if (w_ovf) begin
                     r_quotient  <= bus.dividend;
                     r_remainder <= '0;
                     r_dbz       <= 1'b0;
                     r_ovf       <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_prem  <= w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
               r_work  <= {r_work[WIDTH-2:0], w_qbit};
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_quotient  <= (r_a_neg ^ r_b_neg) ? -r_work : r_work;
               r_remainder <= r_a_neg ? -r_prem : r_prem;
               r_dbz       <= 1'b0;
               r_ovf       <= 1'b0;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Handshake outputs decode the state register only: no input-to-output path.
   assign bus.in_ready    = (r_state == S_IDLE);
   assign bus.out_valid   = (r_state == S_DONE);
   assign bus.busy        = (r_state == S_CALC) || (r_state == S_FIX);
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;
   assign bus.div_by_zero = r_dbz;
   assign bus.overflow    = r_ovf;

endmodule

// File: doc/divider_seq_param.md
Name: divider_seq_param

Overview:
- Parametrised iterative integer divider: WIDTH-bit dividend and divisor in, WIDTH-bit quotient and remainder out.
- Supports signed (truncating, two's-complement) and unsigned modes, selected per operation.
- Uses a valid/ready handshake on both input and output, and flags divide-by-zero and signed overflow with fixed results.
- Sits behind the datapath issue stage as a multi-cycle execution unit; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.

Ports:
- clk  in  1  rising-edge clock.
- sync_rst  in  1  synchronous active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- signed_mode  in  1  1 = signed division, 0 = unsigned; sampled with operands.
- dividend  in  WIDTH  numerator.
- divisor  in  WIDTH  denominator.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- quotient  out  WIDTH  registered quotient.
- remainder  out  WIDTH  registered remainder.
- div_by_zero  out  1  result came from a zero divisor; qualified by out_valid.
- overflow  out  1  result came from signed most-negative / -1; qualified by out_valid.
- busy  out  1  state is CALC or FIX.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on rising clk and priority over all other logic.
- Reset state: IDLE, all outputs 0, except in_ready = 1 on the first cycle after reset deasserts.
- A reset asserted mid-operation discards the in-flight operation with no out_valid pulse.
- FSM states: IDLE, CALC, FIX, DONE.
- in_ready = (state == IDLE). Accept occurs on an edge with in_valid & in_ready.
- IDLE, on accept:
  - Latch signed_mode, the sign of the dividend, and the sign of the divisor; the signs are forced to 0 in unsigned mode.
  - Latch magnitudes |dividend| and |divisor| as WIDTH-bit unsigned values. |-2^(WIDTH-1)| = 2^(WIDTH-1) fits.
  - Clear the partial remainder (WIDTH+1 bits) and the iteration counter (clog2(WIDTH+1) bits).
  - If divisor == 0: go to DONE with quotient = all ones, remainder = dividend (raw), div_by_zero = 1. This applies in both modes.
  - Else if signed_mode, dividend == 2^(WIDTH-1) and divisor == all ones: go to DONE with quotient = dividend, remainder = 0, overflow = 1.
  - Otherwise go to CALC.
- CALC: restoring radix-2 division, one quotient bit per edge, MSB first.
  - Each edge: shift {partial remainder, dividend magnitude} left by 1, then trial-subtract the divisor magnitude.
  - If the trial result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter increments each edge; after exactly WIDTH CALC edges go to FIX.
- FIX (one edge): apply signs and register the outputs.
  - quotient negated if the dividend and divisor signs differ.
  - remainder negated if the dividend sign is set, so the remainder takes the dividend's sign.
  - Flags = 0. Go to DONE.
- DONE: out_valid = 1. quotient, remainder and flags are held stable while out_valid & ~out_ready.
  - On out_valid & out_ready: go to IDLE and clear out_valid. in_ready rises the cycle after.
- Latency, accept edge to first out_valid cycle:
  - Normal operation: WIDTH+1 edges. At WIDTH = 32, out_valid is high from the 33rd edge after accept.
  - Special cases (zero divisor, signed overflow): 1 edge.
- Throughput: one operation per WIDTH+3 cycles at best, with out_ready tied high.
- Inputs are ignored outside IDLE. in_valid held high during CALC does not re-trigger.
- Invariant: |remainder| < |divisor|, and dividend = quotient*divisor + remainder modulo 2^WIDTH.
- No combinational path from any input to out_valid or in_ready.

Test Plan:
- WIDTH=32, unsigned: 100 / 7 -> after 33 edges out_valid=1, quotient=14, remainder=2, flags 0. Then unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
- WIDTH=32, signed, four sign combinations:
  - -100 / 7 -> quotient=-14 (0xFFFFFFF2), remainder=-2.
  - 100 / -7 -> quotient=-14, remainder=2.
  - -100 / -7 -> quotient=14, remainder=-2.
  - 7 / 100 -> quotient=0, remainder=7.
- Special cases:
  - Divisor 0, dividend 0x12345678 (both modes) -> out_valid after 1 edge, quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
  - Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, overflow=1.
  - Unsigned 0x80000000 / 0xFFFFFFFF -> quotient=0, remainder=0x80000000, no flag.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, a new in_valid is not accepted. Then raise out_ready -> IDLE next edge and a new operation is accepted.
- Reset mid-operation: assert sync_rst at CALC iteration 15 -> next edge all outputs 0 and in_ready=1, no out_valid ever seen for the aborted operation. A following operation, 9 / 3, gives quotient=3, remainder=0.
- WIDTH=8 instance: random signed and unsigned sweep of 10k operations vs a reference model (truncating division), including -128 / -1 (overflow) -> quotient=0x80, remainder=0. Latency is exactly 9 edges for normal operations.
